// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker: integrates decoded PS/2 mouse increments into a
// clamped absolute cursor position, tracks button state and press counts,
// and drives the board LEDs through a runtime-selectable display mode.
module mouse_position_tracker #(
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 10,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int Y_INVERT  = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic                 left_button,
  input  logic                 right_button,
  input  logic [8:0]           x_increment,
  input  logic [8:0]           y_increment,
  input  logic                 center,
  input  logic [1:0]           mode,
  output logic [X_WIDTH-1:0]   x_pos,
  output logic [Y_WIDTH-1:0]   y_pos,
  output logic                 left_held,
  output logic                 right_held,
  output logic [CNT_WIDTH-1:0] left_clicks,
  output logic [CNT_WIDTH-1:0] right_clicks,
  output logic [7:0]           led
);

  // Two guard bits above the position width hold both the sign of an
  // underflow and the carry of an overflow without any wrap-around.
  localparam logic signed [X_WIDTH+1:0] X_MAX_S    = (X_WIDTH+2)'(X_MAX);
  localparam logic signed [Y_WIDTH+1:0] Y_MAX_S    = (Y_WIDTH+2)'(Y_MAX);
  localparam logic [X_WIDTH-1:0]        X_CENTER   = X_WIDTH'(X_MAX >> 1);
  localparam logic [Y_WIDTH-1:0]        Y_CENTER   = Y_WIDTH'(Y_MAX >> 1);
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE    = CNT_WIDTH'(1);

  logic signed [X_WIDTH+1:0] dx_ext;
  logic signed [Y_WIDTH+1:0] dy_ext;
  logic signed [X_WIDTH+1:0] x_sum;
  logic signed [Y_WIDTH+1:0] y_sum;
  logic [X_WIDTH-1:0]        x_next;
  logic [Y_WIDTH-1:0]        y_next;
  logic                      left_press;
  logic                      right_press;

  // Only the low three bits of each increment are ever displayed, so only
  // those are kept as the last-increment registers.
  logic [2:0]                last_dx;
  logic [2:0]                last_dy;

  // Sign-extend the increments, form the candidate positions and clamp them
  // into 0..MAX so the cursor pins at the screen edges instead of wrapping.
  always_comb begin
    dx_ext = {{(X_WIDTH-7){x_increment[8]}}, x_increment};
    dy_ext = {{(Y_WIDTH-7){y_increment[8]}}, y_increment};
    x_sum  = $signed({2'b00, x_pos}) + dx_ext;
    if (Y_INVERT != 0) begin
      y_sum = $signed({2'b00, y_pos}) - dy_ext;
    end else begin
      y_sum = $signed({2'b00, y_pos}) + dy_ext;
    end

    x_next = x_sum[X_WIDTH-1:0];
    if (x_sum[X_WIDTH+1]) begin
      x_next = '0;
    end else if (x_sum > X_MAX_S) begin
      x_next = X_MAX_S[X_WIDTH-1:0];
    end

    y_next = y_sum[Y_WIDTH-1:0];
    if (y_sum[Y_WIDTH+1]) begin
      y_next = '0;
    end else if (y_sum > Y_MAX_S) begin
      y_next = Y_MAX_S[Y_WIDTH-1:0];
    end

    left_press  = left_button  & ~left_held;
    right_press = right_button & ~right_held;
  end

  // State register: reset beats center, and center discards any packet
  // arriving in the same cycle; otherwise a valid packet updates everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_pos        <= X_CENTER;
      y_pos        <= Y_CENTER;
      left_held    <= 1'b0;
      right_held   <= 1'b0;
      left_clicks  <= '0;
      right_clicks <= '0;
      last_dx      <= '0;
      last_dy      <= '0;
    end else if (center) begin
      x_pos <= X_CENTER;
      y_pos <= Y_CENTER;
    end else if (pkt_valid) begin
      x_pos      <= x_next;
      y_pos      <= y_next;
      left_held  <= left_button;
      right_held <= right_button;
      last_dx    <= x_increment[2:0];
      last_dy    <= y_increment[2:0];
      if (left_press) begin
        left_clicks <= left_clicks + CNT_ONE;
      end
      if (right_press) begin
        right_clicks <= right_clicks + CNT_ONE;
      end
    end
  end

  // LED display multiplexer, purely combinational so a mode change shows
  // up immediately without waiting for a clock edge.
  always_comb begin
    led = '0;
    unique case (mode)
      2'd0: led = {last_dy, last_dx, left_held, right_held};
      2'd1: led = x_pos[X_WIDTH-1 -: 8];
      2'd2: led = y_pos[Y_WIDTH-1 -: 8];
      2'd3: led = {left_clicks[3:0], right_clicks[3:0]};
      default: led = '0;
    endcase
  end

endmodule

// File: tb/tb_mouse_position_tracker.sv
// tb_mouse_position_tracker: table-driven vectors feed a scoreboard queue;
// each expected record is popped and compared one clock after it is driven.
module tb_mouse_position_tracker;

  typedef struct {
    int         tag;
    logic       rst;
    logic       pv;
    logic       lb;
    logic       rb;
    logic       ctr;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] md;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       elh;
    logic       erh;
    logic [7:0] elc;
    logic [7:0] erc;
    logic [7:0] eled;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic       left_button;
  logic       right_button;
  logic [8:0] x_increment;
  logic [8:0] y_increment;
  logic       center;
  logic [1:0] mode;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       left_held;
  logic       right_held;
  logic [7:0] left_clicks;
  logic [7:0] right_clicks;
  logic [7:0] led;

  int   vectors_applied = 0;
  int   miscompares     = 0;
  vec_t exp_q[$];
  vec_t vecs[21];

  mouse_position_tracker #(
    .X_WIDTH(10), .Y_WIDTH(10), .X_MAX(639), .Y_MAX(479),
    .Y_INVERT(1), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid),
    .left_button(left_button), .right_button(right_button),
    .x_increment(x_increment), .y_increment(y_increment),
    .center(center), .mode(mode),
    .x_pos(x_pos), .y_pos(y_pos),
    .left_held(left_held), .right_held(right_held),
    .left_clicks(left_clicks), .right_clicks(right_clicks),
    .led(led)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  function automatic vec_t mk(input int tag, input logic rst, pv, lb, rb, ctr,
                              input logic [8:0] dx, dy, input logic [1:0] md,
                              input logic [9:0] ex, ey, input logic elh, erh,
                              input logic [7:0] elc, erc, eled);
    vec_t v;
    v.tag = tag; v.rst = rst; v.pv = pv; v.lb = lb; v.rb = rb; v.ctr = ctr;
    v.dx = dx; v.dy = dy; v.md = md; v.ex = ex; v.ey = ey;
    v.elh = elh; v.erh = erh; v.elc = elc; v.erc = erc; v.eled = eled;
    return v;
  endfunction

  task automatic compareField(input int tag, input string name,
                              input logic [31:0] actual, input logic [31:0] expected);
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL v%0d %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, name, actual, actual, expected, expected);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a record");
      return;
    end
    e = exp_q.pop_front();
    vectors_applied++;
    compareField(e.tag, "x_pos",        32'(x_pos),        32'(e.ex));
    compareField(e.tag, "y_pos",        32'(y_pos),        32'(e.ey));
    compareField(e.tag, "left_held",    32'(left_held),    32'(e.elh));
    compareField(e.tag, "right_held",   32'(right_held),   32'(e.erh));
    compareField(e.tag, "left_clicks",  32'(left_clicks),  32'(e.elc));
    compareField(e.tag, "right_clicks", 32'(right_clicks), 32'(e.erc));
    compareField(e.tag, "led",          32'(led),          32'(e.eled));
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset        = v.rst;
    pkt_valid    = v.pv;
    left_button  = v.lb;
    right_button = v.rb;
    center       = v.ctr;
    x_increment  = v.dx;
    y_increment  = v.dy;
    mode         = v.md;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [7:0] lc_model;
    logic [7:0] seq_lb;
    logic [7:0] seq_lc;

    reset = 1'b1; pkt_valid = 1'b0; left_button = 1'b0; right_button = 1'b0;
    center = 1'b0; x_increment = '0; y_increment = '0; mode = 2'd0;

    //        tag rst pv lb rb ctr dx      dy      md  ex   ey   lh rh lc rc led
    vecs[0]  = mk(0,  1, 0, 0, 0, 0, 9'd0,   9'd0,   0, 319, 239, 0, 0, 0, 0, 8'h00);
    vecs[1]  = mk(1,  0, 0, 0, 0, 0, 9'd0,   9'd0,   0, 319, 239, 0, 0, 0, 0, 8'h00);
    vecs[2]  = mk(2,  0, 1, 1, 0, 0, 9'd5,   9'd3,   0, 324, 236, 1, 0, 1, 0, 8'h76);
    vecs[3]  = mk(3,  0, 1, 1, 0, 0, 9'd0,   9'd0,   0, 324, 236, 1, 0, 1, 0, 8'h02);
    vecs[4]  = mk(4,  0, 1, 0, 1, 0, 9'h1FF, 9'h1FF, 0, 323, 237, 0, 1, 1, 1, 8'hFD);
    vecs[5]  = mk(5,  0, 1, 1, 1, 0, 9'd0,   9'd0,   0, 323, 237, 1, 1, 2, 1, 8'h03);
    vecs[6]  = mk(6,  0, 0, 1, 1, 1, 9'd0,   9'd0,   0, 319, 239, 1, 1, 2, 1, 8'h03);
    vecs[7]  = mk(7,  0, 1, 1, 1, 0, 9'd255, 9'd0,   1, 574, 239, 1, 1, 2, 1, 8'h8F);
    vecs[8]  = mk(8,  0, 1, 1, 1, 0, 9'd255, 9'd0,   1, 639, 239, 1, 1, 2, 1, 8'h9F);
    vecs[9]  = mk(9,  0, 1, 1, 1, 0, 9'd255, 9'd0,   1, 639, 239, 1, 1, 2, 1, 8'h9F);
    vecs[10] = mk(10, 0, 1, 1, 1, 0, 9'h100, 9'd0,   0, 383, 239, 1, 1, 2, 1, 8'h03);
    vecs[11] = mk(11, 0, 1, 1, 1, 0, 9'h100, 9'd0,   2, 127, 239, 1, 1, 2, 1, 8'h3B);
    vecs[12] = mk(12, 0, 1, 1, 1, 0, 9'h100, 9'd0,   3, 0,   239, 1, 1, 2, 1, 8'h21);
    vecs[13] = mk(13, 0, 1, 1, 1, 0, 9'h100, 9'h100, 2, 0,   479, 1, 1, 2, 1, 8'h77);
    vecs[14] = mk(14, 0, 1, 1, 1, 0, 9'd255, 9'd255, 1, 255, 224, 1, 1, 2, 1, 8'h3F);
    vecs[15] = mk(15, 0, 1, 1, 1, 0, 9'd0,   9'd255, 0, 255, 0,   1, 1, 2, 1, 8'hE3);
    vecs[16] = mk(16, 0, 1, 0, 0, 1, 9'd10,  9'd0,   0, 319, 239, 1, 1, 2, 1, 8'hE3);
    vecs[17] = mk(17, 0, 1, 0, 0, 0, 9'd0,   9'd0,   3, 319, 239, 0, 0, 2, 1, 8'h21);
    vecs[18] = mk(18, 0, 1, 1, 0, 0, 9'd0,   9'd0,   3, 319, 239, 1, 0, 3, 1, 8'h31);
    vecs[19] = mk(19, 0, 0, 0, 1, 0, 9'd100, 9'd0,   3, 319, 239, 1, 0, 3, 1, 8'h31);
    vecs[20] = mk(20, 1, 1, 1, 1, 0, 9'd5,   9'd0,   0, 319, 239, 0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
    end

    // 256 press/release pairs: the left counter must wrap back to zero.
    lc_model = 8'd0;
    for (int i = 0; i < 256; i++) begin
      lc_model = lc_model + 8'd1;
      applyStimulus(mk(100 + 2*i, 0, 1, 1, 0, 0, 9'd0, 9'd0, 3, 319, 239, 1, 0,
                       lc_model, 8'd0, {lc_model[3:0], 4'h0}));
      applyStimulus(mk(101 + 2*i, 0, 1, 0, 0, 0, 9'd0, 9'd0, 3, 319, 239, 0, 0,
                       lc_model, 8'd0, {lc_model[3:0], 4'h0}));
    end

    // Left pattern 1,1,0,1: only the two rising presses count.
    seq_lb = 8'b0000_1011;
    seq_lc = 8'd0;
    for (int i = 0; i < 4; i++) begin
      logic prev;
      prev = (i == 0) ? 1'b0 : seq_lb[i-1];
      if (seq_lb[i] && !prev) seq_lc = seq_lc + 8'd1;
      applyStimulus(mk(1000 + i, 0, 1, seq_lb[i], 0, 0, 9'd0, 9'd0, 3, 319, 239,
                       seq_lb[i], 0, seq_lc, 8'd0, {seq_lc[3:0], 4'h0}));
    end

    // Mode change without any clock edge: led follows immediately.
    @(negedge clk);
    mode = 2'd1;
    #1;
    vectors_applied++;
    compareField(2000, "led_mode_switch", 32'(led), 32'h4F);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: got %0d records, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/mouse_position_tracker.md
Name: mouse_position_tracker

Overview:
- Consumes decoded PS/2 mouse packets: button states plus 9-bit two's-complement X/Y increments, with a one-cycle valid strobe.
- Integrates the increments into clamped absolute X/Y cursor positions and counts button clicks.
- Drives the 8 board LEDs through a runtime-selectable display mode.
- Sits between ps2_mouse_interface and the board top level. Mode 0 gives the current LED mapping (buttons plus low increment bits).

Parameters:
- X_WIDTH, 10, width of x_pos; X_MAX must be < 2^X_WIDTH.
- Y_WIDTH, 10, width of y_pos; Y_MAX must be < 2^Y_WIDTH.
- X_MAX, 639, largest legal x_pos.
- Y_MAX, 479, largest legal y_pos.
- Y_INVERT, 1, 1: positive dy decreases y_pos (screen coordinates); 0: positive dy increases y_pos.
- CNT_WIDTH, 8, width of each click counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pkt_valid  in  1  one-cycle strobe: packet fields are valid this cycle.
- left_button  in  1  left button state in the packet.
- right_button  in  1  right button state in the packet.
- x_increment  in  9  signed dx, range -256..255.
- y_increment  in  9  signed dy, range -256..255.
- center  in  1  synchronous recenter request.
- mode  in  2  LED display mode select.
- x_pos  out  X_WIDTH  absolute X position, 0..X_MAX.
- y_pos  out  Y_WIDTH  absolute Y position, 0..Y_MAX.
- left_held  out  1  registered left button state from the last packet.
- right_held  out  1  registered right button state from the last packet.
- left_clicks  out  CNT_WIDTH  count of left-button press events.
- right_clicks  out  CNT_WIDTH  count of right-button press events.
- led  out  8  board LEDs.

Behaviour:
- Reset: synchronous, active-high, dominates all other inputs.
  - x_pos = X_MAX>>1 and y_pos = Y_MAX>>1 (defaults: 319 and 239).
  - left_held, right_held, both click counters, and the last-increment registers all 0.
  - led therefore reflects the reset state from the first clock edge after reset.
- Packet update: on an edge where pkt_valid=1, center=0 and reset=0, the following registers update together. New values are visible the cycle after the strobe (latency 1).
  - x_pos and y_pos: new clamped positions.
  - left_held, right_held: packet button states.
  - click counters: incremented per the press rule below.
  - last-increment registers: x_increment and y_increment captured.
- Arithmetic:
  - Sign-extend the increments and compute in signed (WIDTH+2)-bit: nx = x_pos + dx; ny = y_pos - dy (Y_INVERT=1) or y_pos + dy (Y_INVERT=0).
  - Clamp: a negative result gives 0; a result above MAX gives MAX; otherwise take the result.
  - No wrap-around of positions under any input.
- Click detection: a press event is a packet with button=1 whose previous held state was 0.
  - The matching counter increments by 1 and wraps modulo 2^CNT_WIDTH.
  - A held button across consecutive packets does not count again.
  - Release events are not counted.
- Center: center=1 (and reset=0) loads X_MAX>>1 and Y_MAX>>1.
  - Held states, counters and last increments are unchanged.
  - If pkt_valid=1 in the same cycle, that packet is discarded entirely.
- Idle: with pkt_valid=0 and center=0, all state holds.
- LED modes (combinational from registered state; mode changes take effect the same cycle):
  - 0: led[0]=right_held, led[1]=left_held, led[4:2]=last dx[2:0], led[7:5]=last dy[2:0].
  - 1: led = x_pos[X_WIDTH-1 -: 8].
  - 2: led = y_pos[Y_WIDTH-1 -: 8].
  - 3: led[7:4] = left_clicks[3:0], led[3:0] = right_clicks[3:0].
- Inputs are already synchronous to clk. The block adds no synchronisers.

Test Plan:
- Reset, then idle: x_pos=319, y_pos=239, led=0 in mode 0, counters 0, with defaults.
- One packet dx=+5, dy=+3, left=1 (Y_INVERT=1) -> next cycle x_pos=324, y_pos=236, left_held=1, left_clicks=1, mode 0 led=8'b011_101_10.
- Clamp: from x=319, send dx=+255 twice then a third time -> x_pos 574, 639, 639. Then dx=-256 three times -> 383, 127, 0. Never wraps.
- Clicks: left=1,1,0,1 across four packets -> left_clicks=2. Send 256 press/release pairs with CNT_WIDTH=8 -> the counter wraps back to its start value.
- pkt_valid and center asserted in the same cycle with dx=+10 -> x_pos=319, held and counters unchanged. Assert reset during a packet strobe -> all outputs at reset values.
- Mode sweep at x=639, y=479 (binary 1001111111 and 0111011111): mode 1 led=8'h9F, mode 2 led=8'h77. Mode 3 with left_clicks=3, right_clicks=1 gives led=8'h31.
